// File: rtl/bus_arbiter.sv
// bus_arbiter: two-port arbiter feeding one downstream bus-controller master port.
// A granted transfer is latched and issued, then completion data is returned to the owner
// together with a one-cycle done pulse. A stuck WAIT phase ends with an ERROR response.
//
// state   | meaning
// --------+----------------------------------------------------------------
// S_IDLE  | no transfer; picks a winner when a req is high and no done is pending
// S_ISSUE | bus_start high with latched command, waiting for bus_ready
// S_WAIT  | waiting for completion (bus_ready) or the WAIT-cycle timeout
module bus_arbiter #(
    parameter int RR_ENABLE = 1,
    parameter int TIMEOUT   = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        m0_req,
    input  logic        m1_req,
    input  logic        m0_write,
    input  logic        m1_write,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m0_wdata,
    input  logic [31:0] m1_wdata,
    output logic [31:0] m0_rdata,
    output logic [31:0] m1_rdata,
    output logic        m0_resp,
    output logic        m1_resp,
    output logic        m0_done,
    output logic        m1_done,
    output logic        bus_start,
    output logic        bus_write,
    output logic [31:0] bus_address,
    output logic [31:0] bus_write_data,
    input  logic [31:0] bus_read_data,
    input  logic        bus_response,
    input  logic        bus_ready,
    output logic        owner
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] WAIT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    state_t        state_q;
    logic          bus_start_q;
    logic          bus_write_q;
    logic [31:0]   bus_address_q;
    logic [31:0]   bus_write_data_q;
    logic [31:0]   m0_rdata_q;
    logic [31:0]   m1_rdata_q;
    logic          m0_resp_q;
    logic          m1_resp_q;
    logic          m0_done_q;
    logic          m1_done_q;
    logic          owner_q;
    logic          last_served_q;
    logic [CW-1:0] wait_cnt_q;

    logic          grant_d;
    logic          sel_write_d;
    logic [31:0]   sel_addr_d;
    logic [31:0]   sel_wdata_d;
    logic          timed_out_d;
    logic [31:0]   end_rdata_d;
    logic          end_resp_d;

    // Winner selection and the command fields belonging to the winner.
    always_comb begin
        grant_d = ~m0_req;
        if ((RR_ENABLE != 0) && m0_req && m1_req) begin
            grant_d = ~last_served_q;
        end
        sel_write_d = grant_d ? m1_write : m0_write;
        sel_addr_d  = grant_d ? m1_addr  : m0_addr;
        sel_wdata_d = grant_d ? m1_wdata : m0_wdata;
    end

    // Completion payload: bus data on a real completion, ERROR with zero data on timeout.
    always_comb begin
        timed_out_d = (wait_cnt_q == WAIT_LAST) && !bus_ready;
        end_rdata_d = bus_ready ? bus_read_data : 32'h0;
        end_resp_d  = bus_ready ? bus_response  : 1'b1;
    end

    // Arbitration FSM with registered bus command and requester completion outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q          <= S_IDLE;
            bus_start_q      <= 1'b0;
            bus_write_q      <= 1'b0;
            bus_address_q    <= 32'h0;
            bus_write_data_q <= 32'h0;
            m0_rdata_q       <= 32'h0;
            m1_rdata_q       <= 32'h0;
            m0_resp_q        <= 1'b0;
            m1_resp_q        <= 1'b0;
            m0_done_q        <= 1'b0;
            m1_done_q        <= 1'b0;
            owner_q          <= 1'b0;
            last_served_q    <= 1'b1;
            wait_cnt_q       <= '0;
        end else begin
            m0_done_q <= 1'b0;
            m1_done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    // The done cycle is itself an IDLE cycle; skipping selection there
                    // guarantees the one-cycle gap between grants.
                    if ((m0_req || m1_req) && !m0_done_q && !m1_done_q) begin
                        owner_q          <= grant_d;
                        bus_write_q      <= sel_write_d;
                        bus_address_q    <= sel_addr_d;
                        bus_write_data_q <= sel_wdata_d;
                        bus_start_q      <= 1'b1;
                        state_q          <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (bus_ready) begin
                        bus_start_q <= 1'b0;
                        wait_cnt_q  <= '0;
                        state_q     <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (bus_ready || timed_out_d) begin
                        if (owner_q) begin
                            m1_rdata_q <= end_rdata_d;
                            m1_resp_q  <= end_resp_d;
                            m1_done_q  <= 1'b1;
                        end else begin
                            m0_rdata_q <= end_rdata_d;
                            m0_resp_q  <= end_resp_d;
                            m0_done_q  <= 1'b1;
                        end
                        last_served_q <= owner_q;
                        state_q       <= S_IDLE;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + 1'b1;
                    end
                end
                default: begin
                    bus_start_q <= 1'b0;
                    state_q     <= S_IDLE;
                end
            endcase
        end
    end

    assign bus_start      = bus_start_q;
    assign bus_write      = bus_write_q;
    assign bus_address    = bus_address_q;
    assign bus_write_data = bus_write_data_q;
    assign m0_rdata       = m0_rdata_q;
    assign m1_rdata       = m1_rdata_q;
    assign m0_resp        = m0_resp_q;
    assign m1_resp        = m1_resp_q;
    assign m0_done        = m0_done_q;
    assign m1_done        = m1_done_q;
    assign owner          = owner_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter: drives a round-robin and a fixed-priority arbiter with identical stimulus
// and checks both against a transaction-level model of the arbitration rules.
module tb_bus_arbiter;

    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        m0_req = 1'b0, m1_req = 1'b0, m0_write = 1'b0, m1_write = 1'b0;
    logic [31:0] m0_addr = '0, m1_addr = '0, m0_wdata = '0, m1_wdata = '0;
    logic [31:0] bus_read_data = '0;
    logic        bus_response = 1'b0, bus_ready = 1'b0;

    logic        o_start [2];
    logic        o_write [2];
    logic        o_owner [2];
    logic        o_done0 [2];
    logic        o_done1 [2];
    logic        o_resp0 [2];
    logic        o_resp1 [2];
    logic [31:0] o_addr  [2];
    logic [31:0] o_wdata [2];
    logic [31:0] o_rdata0[2];
    logic [31:0] o_rdata1[2];

    int tests  = 0;
    int errors = 0;

    // Reference model: index 0 = round-robin instance, 1 = fixed-priority instance.
    logic        last_q   [2];
    logic        win      [2];
    logic [31:0] lat_addr [2];
    logic [31:0] lat_wdata[2];
    logic        lat_write[2];
    logic [31:0] m_rdata  [2][2];
    logic        m_resp   [2][2];

    always #5 clk = ~clk;

    bus_arbiter #(.RR_ENABLE(1), .TIMEOUT(TO)) dut_rr (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m1_req(m1_req), .m0_write(m0_write), .m1_write(m1_write),
        .m0_addr(m0_addr), .m1_addr(m1_addr), .m0_wdata(m0_wdata), .m1_wdata(m1_wdata),
        .m0_rdata(o_rdata0[0]), .m1_rdata(o_rdata1[0]), .m0_resp(o_resp0[0]), .m1_resp(o_resp1[0]),
        .m0_done(o_done0[0]), .m1_done(o_done1[0]),
        .bus_start(o_start[0]), .bus_write(o_write[0]), .bus_address(o_addr[0]),
        .bus_write_data(o_wdata[0]), .bus_read_data(bus_read_data),
        .bus_response(bus_response), .bus_ready(bus_ready), .owner(o_owner[0])
    );

    bus_arbiter #(.RR_ENABLE(0), .TIMEOUT(TO)) dut_fp (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m1_req(m1_req), .m0_write(m0_write), .m1_write(m1_write),
        .m0_addr(m0_addr), .m1_addr(m1_addr), .m0_wdata(m0_wdata), .m1_wdata(m1_wdata),
        .m0_rdata(o_rdata0[1]), .m1_rdata(o_rdata1[1]), .m0_resp(o_resp0[1]), .m1_resp(o_resp1[1]),
        .m0_done(o_done0[1]), .m1_done(o_done1[1]),
        .bus_start(o_start[1]), .bus_write(o_write[1]), .bus_address(o_addr[1]),
        .bus_write_data(o_wdata[1]), .bus_read_data(bus_read_data),
        .bus_response(bus_response), .bus_ready(bus_ready), .owner(o_owner[1])
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk1(input string tag, input int d, input logic obs, input logic exp_v);
        tests++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s dut%0d: observed %b expected %b", tag, d, obs, exp_v);
        end
    endtask

    task automatic chk32(input string tag, input int d, input logic [31:0] obs, input logic [31:0] exp_v);
        tests++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s dut%0d: observed %h expected %h", tag, d, obs, exp_v);
        end
    endtask

    // Arbitration rule: fixed priority serves port 0 whenever it asks; round-robin
    // serves the port not served last on a tie, otherwise the lone requester.
    function automatic logic pick(input int d, input logic [1:0] p);
        if (d == 1) return !p[0];
        if (p == 2'b11) return !last_q[0];
        return p[1];
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            last_q[d] = 1'b1;
            for (int m = 0; m < 2; m++) begin
                m_rdata[d][m] = '0;
                m_resp[d][m]  = 1'b0;
            end
        end
    endtask

    task automatic check_reset(input string tag);
        for (int d = 0; d < 2; d++) begin
            chk1 (tag, d, o_start[d], 1'b0);
            chk1 (tag, d, o_write[d], 1'b0);
            chk32(tag, d, o_addr[d], 32'h0);
            chk32(tag, d, o_wdata[d], 32'h0);
            chk1 (tag, d, o_owner[d], 1'b0);
            chk1 (tag, d, o_done0[d], 1'b0);
            chk1 (tag, d, o_done1[d], 1'b0);
            chk32(tag, d, o_rdata0[d], 32'h0);
            chk32(tag, d, o_rdata1[d], 32'h0);
            chk1 (tag, d, o_resp0[d], 1'b0);
            chk1 (tag, d, o_resp1[d], 1'b0);
        end
    endtask

    task automatic check_hold(input string tag);
        for (int d = 0; d < 2; d++) begin
            chk1 (tag, d, o_start[d], 1'b0);
            chk1 (tag, d, o_done0[d], 1'b0);
            chk1 (tag, d, o_done1[d], 1'b0);
            chk1 (tag, d, o_owner[d], win[d]);
            chk32(tag, d, o_addr[d], lat_addr[d]);
            chk32(tag, d, o_rdata0[d], m_rdata[d][0]);
            chk32(tag, d, o_rdata1[d], m_rdata[d][1]);
            chk1 (tag, d, o_resp0[d], m_resp[d][0]);
            chk1 (tag, d, o_resp1[d], m_resp[d][1]);
        end
    endtask

    task automatic check_issue();
        for (int d = 0; d < 2; d++) begin
            chk1 ("issue_start", d, o_start[d], 1'b1);
            chk32("issue_addr",  d, o_addr[d], lat_addr[d]);
            chk32("issue_wdata", d, o_wdata[d], lat_wdata[d]);
            chk1 ("issue_write", d, o_write[d], lat_write[d]);
            chk1 ("issue_owner", d, o_owner[d], win[d]);
            chk1 ("issue_done0", d, o_done0[d], 1'b0);
            chk1 ("issue_done1", d, o_done1[d], 1'b0);
        end
    endtask

    // One transfer, entered from an IDLE cycle with no done pending: k ISSUE cycles with
    // bus_ready low, then w WAIT cycles with bus_ready low (w >= TO forces the timeout).
    task automatic do_xfer(input logic [1:0] p, input int k, input int w, input bit drop,
                           input logic [1:0] wr, input logic [31:0] a0, input logic [31:0] a1,
                           input logic [31:0] rd, input logic rsp);
        logic [31:0] e_rd;
        logic        e_rsp;
        bit          fin;
        m0_req = p[0];  m1_req = p[1];
        m0_write = wr[0]; m1_write = wr[1];
        m0_addr = a0;  m1_addr = a1;
        m0_wdata = $urandom; m1_wdata = $urandom;
        bus_ready = 1'b0;
        for (int d = 0; d < 2; d++) begin
            win[d]       = pick(d, p);
            lat_addr[d]  = win[d] ? m1_addr  : m0_addr;
            lat_wdata[d] = win[d] ? m1_wdata : m0_wdata;
            lat_write[d] = win[d] ? m1_write : m0_write;
        end
        step();
        // Requester fields change after grant; the bus command must keep the latched copy.
        m0_addr = $urandom; m1_addr = $urandom; m0_wdata = $urandom; m1_wdata = $urandom;
        m0_write = ~m0_write; m1_write = ~m1_write;
        if (drop) begin
            m0_req = 1'b0;
            m1_req = 1'b0;
        end
        for (int i = 0; i <= k; i++) begin
            check_issue();
            bus_ready     = (i == k);
            bus_read_data = $urandom;
            bus_response  = 1'($urandom);
            step();
        end
        fin   = 1'b0;
        e_rd  = 32'h0;
        e_rsp = 1'b1;
        for (int j = 0; j < TO && !fin; j++) begin
            check_hold("wait");
            bus_read_data = $urandom;
            bus_response  = 1'($urandom);
            if (j == w) begin
                bus_ready     = 1'b1;
                bus_read_data = rd;
                bus_response  = rsp;
                e_rd          = rd;
                e_rsp         = rsp;
                fin           = 1'b1;
            end else begin
                bus_ready = 1'b0;
                if (j == TO - 1) fin = 1'b1;
            end
            step();
        end
        for (int d = 0; d < 2; d++) begin
            m_rdata[d][win[d]] = e_rd;
            m_resp[d][win[d]]  = e_rsp;
            last_q[d]          = win[d];
            chk1 ("done_owner", d, win[d] ? o_done1[d] : o_done0[d], 1'b1);
            chk1 ("done_other", d, win[d] ? o_done0[d] : o_done1[d], 1'b0);
            chk32("rdata0", d, o_rdata0[d], m_rdata[d][0]);
            chk32("rdata1", d, o_rdata1[d], m_rdata[d][1]);
            chk1 ("resp0",  d, o_resp0[d], m_resp[d][0]);
            chk1 ("resp1",  d, o_resp1[d], m_resp[d][1]);
            chk1 ("done_start", d, o_start[d], 1'b0);
            chk1 ("done_ownerid", d, o_owner[d], win[d]);
        end
        // Requests seen during the done cycle must not start a grant; this pattern is
        // replaced before the next selection edge, so it is never served either.
        m0_req    = 1'($urandom);
        m1_req    = 1'($urandom);
        bus_ready = 1'($urandom);
        step();
        check_hold("gap");
    endtask

    initial begin
        m0_req = 1'b1; m1_req = 1'b1; bus_ready = 1'b1;
        m0_addr = $urandom; m1_addr = $urandom;
        #1 rst = 1'b0;
        #2 check_reset("rst_init");
        step();
        step();
        check_reset("rst_hold");
        m0_req = 1'b0; m1_req = 1'b0; bus_ready = 1'b0;
        rst = 1'b1;
        model_reset();
        step();
        check_reset("idle_after_rst");

        // First tie after reset goes to port 0, then round-robin alternates.
        for (int n = 0; n < 4; n++)
            do_xfer(2'b11, 0, 0, 1'b0, 2'($urandom), $urandom, $urandom, $urandom, 1'($urandom));

        // Single minimum-latency read from port 0.
        do_xfer(2'b01, 0, 0, 1'b0, 2'b00, 32'h10, $urandom, 32'hDEADBEEF, 1'b0);
        // Five stalled ISSUE cycles.
        do_xfer(2'b10, 5, 0, 1'b0, 2'($urandom), $urandom, $urandom, $urandom, 1'b0);
        // WAIT stuck low: timeout with ERROR and zero data.
        do_xfer(2'b01, 0, TO + 3, 1'b0, 2'b00, $urandom, $urandom, $urandom, 1'b0);
        // bus_ready arrives in the last allowed WAIT cycle: normal completion.
        do_xfer(2'b11, 1, TO - 1, 1'b0, 2'b00, $urandom, $urandom, $urandom, 1'b0);
        // Requests dropped right after grant still complete.
        do_xfer(2'b11, 0, 2, 1'b1, 2'b11, $urandom, $urandom, $urandom, 1'b1);

        for (int n = 0; n < 40; n++) begin
            int w;
            w = ($urandom_range(0, 5) == 0) ? int'($urandom_range(TO - 2, TO + 2))
                                            : int'($urandom_range(0, 3));
            do_xfer(2'($urandom_range(1, 3)), int'($urandom_range(0, 3)), w, 1'($urandom),
                    2'($urandom), $urandom, $urandom, $urandom, 1'($urandom));
        end

        // Reset in the middle of WAIT abandons the transfer without a done pulse.
        m0_req = 1'b1; m1_req = 1'b0; bus_ready = 1'b0;
        step();
        bus_ready = 1'b1;
        step();
        bus_ready     = 1'b1;
        bus_read_data = $urandom;
        #2 rst = 1'b0;
        #1 check_reset("rst_mid_wait");
        for (int n = 0; n < 3; n++) begin
            step();
            check_reset("rst_mid_hold");
        end
        m0_req = 1'b0; m1_req = 1'b0; bus_ready = 1'b0;
        rst = 1'b1;
        model_reset();
        step();
        check_reset("idle_after_rst2");

        do_xfer(2'b11, 0, 0, 1'b0, 2'($urandom), $urandom, $urandom, $urandom, 1'($urandom));
        do_xfer(2'b11, 2, 1, 1'b0, 2'($urandom), $urandom, $urandom, $urandom, 1'($urandom));
        do_xfer(2'b10, 0, 0, 1'b0, 2'($urandom), $urandom, $urandom, $urandom, 1'($urandom));

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 SHALL have parameter RR_ENABLE, default 1, meaning 1 = round-robin, 0 = fixed priority with port 0 winning.
REQ-002 SHALL have parameter TIMEOUT, default 16, meaning the maximum number of cycles spent in WAIT before the arbiter aborts the transfer.
REQ-003 SHALL have port clk, input, 1 bit: clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, asynchronous, active-low.
REQ-005 SHALL have ports m0_req and m1_req, input, 1 bit each: requester holds high until its done pulse.
REQ-006 SHALL have ports m0_write and m1_write, input, 1 bit each: 1 = write, 0 = read.
REQ-007 SHALL have ports m0_addr and m1_addr, input, 32 bits each: transfer address.
REQ-008 SHALL have ports m0_wdata and m1_wdata, input, 32 bits each: write data.
REQ-009 SHALL have ports m0_rdata and m1_rdata, output, 32 bits each: read data, valid while the matching done is high.
REQ-010 SHALL have ports m0_resp and m1_resp, output, 1 bit each: 0 = OKAY, 1 = ERROR, valid while the matching done is high.
REQ-011 SHALL have ports m0_done and m1_done, output, 1 bit each: one-cycle completion pulse.
REQ-012 SHALL have ports bus_start, bus_write, bus_address[31:0] and bus_write_data[31:0], all outputs: the downstream bus-controller master request.
REQ-013 SHALL have ports bus_read_data[31:0], bus_response and bus_ready, all inputs: the downstream completion signals.
REQ-014 SHALL have port owner, output, 1 bit: index of the currently granted requester, for debug.

Function
REQ-015 SHALL implement three states, IDLE, ISSUE and WAIT, held in registers.
REQ-016 In IDLE with at least one req high, SHALL select the winner, latch its write, addr and wdata, set owner to the winner, and enter ISSUE on the next edge.
REQ-017 Winner selection with RR_ENABLE=1 SHALL favour the port other than last_served when both request; with RR_ENABLE=0 it SHALL pick port 0 whenever m0_req=1.
REQ-018 In ISSUE SHALL drive bus_start=1 with the latched write/address/data, and move to WAIT on the edge where bus_ready=1; while bus_ready=0 it SHALL stay in ISSUE with bus_start held.
REQ-019 In IDLE and WAIT SHALL hold bus_start=0; bus_write, bus_address and bus_write_data SHALL always reflect the latched values.
REQ-020 In WAIT on the edge where bus_ready=1, SHALL register bus_read_data and bus_response into the owner's rdata and resp, pulse the owner's done for exactly one cycle, set last_served to owner, and return to IDLE.
REQ-021 Minimum latency SHALL be: req sampled at edge 0, ISSUE during cycle 1, WAIT during cycle 2, done high during cycle 3, with bus_ready held at 1.
REQ-022 SHALL leave one IDLE cycle between consecutive grants; done and the next selection never coincide.
REQ-023 A WAIT cycle counter SHALL clear on entry to WAIT; if it reaches TIMEOUT-1 with bus_ready=0, the arbiter SHALL complete with resp=1, rdata=0, pulse done and enter IDLE.
REQ-024 A req that drops before grant SHALL be ignored; a req that drops after grant SHALL NOT abort the transfer, and done is still pulsed.
REQ-025 The non-owner's done SHALL stay 0 and its rdata/resp SHALL keep their previous values.

Reset
REQ-026 With rst=0, SHALL asynchronously set: state=IDLE, bus_start=0, bus_write=0, bus_address=0, bus_write_data=0, m0_done=m1_done=0, m0_rdata=m1_rdata=0, m0_resp=m1_resp=0, owner=0, last_served=1 (so port 0 wins the first tie), timeout counter=0.
REQ-027 Reset asserted mid-transfer SHALL abandon the transfer without a done pulse; the first grant after release follows REQ-016.

Verification
REQ-028 Single read: m0_req=1, addr=0x10, bus_ready=1, bus_read_data=0xDEADBEEF -> m0_done high in cycle 3, m0_rdata=0xDEADBEEF, m0_resp=0.
REQ-029 Round-robin: both req held, RR_ENABLE=1 -> grants alternate 0,1,0,1; done pulses every 4 cycles.
REQ-030 Fixed priority: both req held, RR_ENABLE=0 -> port 0 is always served and m1_done is never asserted.
REQ-031 Stall: bus_ready=0 for 5 cycles in ISSUE -> bus_start stays 1 with a stable address; done comes 5 cycles later than the minimum.
REQ-032 Timeout: bus_ready stuck at 0 in WAIT with TIMEOUT=16 -> done after 16 WAIT cycles, resp=1, rdata=0.
REQ-033 Reset mid-WAIT: rst=0 -> no done pulse, all outputs at reset values immediately, normal operation after release.
